// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its round-robin scheduler: opcode
// encodings, scheduler state encoding and the illegal-opcode check.
`timescale 1ns/1ps

package alu_pkg;

  localparam logic [3:0] ADD            = 4'b0000;
  localparam logic [3:0] SUB            = 4'b0001;
  localparam logic [3:0] AND            = 4'b0010;
  localparam logic [3:0] OR             = 4'b0011;
  localparam logic [3:0] XOR            = 4'b0100;
  localparam logic [3:0] SHL_LOGICAL    = 4'b0110;
  localparam logic [3:0] SHR_LOGICAL    = 4'b0111;
  localparam logic [3:0] SHR_ARITHMETIC = 4'b1000;
  localparam logic [3:0] LESS_THAN      = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_e;

  // 0101 and everything from 1010 upward has no ALU operation behind it.
  function automatic logic is_illegal_sel(input logic [3:0] sel);
    return (sel == 4'b0101) || (sel >= 4'b1010);
  endfunction

endpackage

// File: rtl/alu.sv
// Single combinational 32-bit ALU. Shift amounts use operand_1[4:0];
// LESS_THAN is a signed compare returning 1 or 0.
`timescale 1ns/1ps

module alu
  import alu_pkg::*;
(
  input  logic [3:0]  ALU_Sel,
  input  logic [31:0] operand_0,
  input  logic [31:0] operand_1,
  output logic [31:0] result
);

  // Operation select; unused encodings give zero.
  always_comb begin
    result = '0;
    case (ALU_Sel)
      ADD:            result = operand_0 + operand_1;
      SUB:            result = operand_0 - operand_1;
      AND:            result = operand_0 & operand_1;
      OR:             result = operand_0 | operand_1;
      XOR:            result = operand_0 ^ operand_1;
      SHL_LOGICAL:    result = operand_0 << operand_1[4:0];
      SHR_LOGICAL:    result = operand_0 >> operand_1[4:0];
      SHR_ARITHMETIC: result = $signed(operand_0) >>> operand_1[4:0];
      LESS_THAN:      result = ($signed(operand_0) < $signed(operand_1)) ? 32'd1 : 32'd0;
      default:        result = '0;
    endcase
  end

endmodule

// File: rtl/rr_picker.sv
// Round-robin picker: one-hot grant to the first requester above
// last_grant, wrapping around. Reusable by any shared resource.
`timescale 1ns/1ps

module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  logic [IDX_W-1:0] idx;

  // Scan last_grant+1 .. last_grant+N (mod N); the first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IDX_W'((int'(last_grant) + k) % N);
      if (!grant_any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one ALU between NUM_REQ requesters with round-robin arbitration
// and a registered, back-pressurable response.
// Optional build macro ALU_RR_SCHEDULER_PERF_EN adds per-requester grant
// counters (grant_cnt) and a response stall counter (stall_cnt).
//
// state | meaning
// IDLE  | arbitrate; grant and latch the winner's operation
// EXEC  | latched operation drives the ALU; result captured at the edge
// RESP  | response held until resp_ready
`timescale 1ns/1ps

module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [4*NUM_REQ-1:0]  req_sel,
  input  logic [32*NUM_REQ-1:0] req_op0,
  input  logic [32*NUM_REQ-1:0] req_op1,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [31:0]           resp_result,
  output logic                  resp_err,
  output logic                  busy
`ifdef ALU_RR_SCHEDULER_PERF_EN
  ,
  output logic [32*NUM_REQ-1:0] grant_cnt,
  output logic [31:0]           stall_cnt
`endif
);

  sched_state_e state_q, state_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic [3:0]      sel_q, sel_d;
  logic [31:0]     op0_q, op0_d;
  logic [31:0]     op1_q, op1_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            resp_valid_q, resp_valid_d;
  logic [ID_W-1:0] resp_id_q, resp_id_d;
  logic [31:0]     resp_result_q, resp_result_d;
  logic            resp_err_q, resp_err_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;
  logic [3:0]         win_sel;
  logic [31:0]        win_op0, win_op1;
  logic [31:0]        alu_result;

  rr_picker #(.N(NUM_REQ), .IDX_W(ID_W)) u_picker (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (pick_grant),
    .grant_idx  (pick_idx),
    .grant_any  (pick_any)
  );

  alu u_alu (
    .ALU_Sel   (sel_q),
    .operand_0 (op0_q),
    .operand_1 (op1_q),
    .result    (alu_result)
  );

  // Route the picked requester's payload.
  always_comb begin
    win_sel = '0;
    win_op0 = '0;
    win_op1 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) begin
        win_sel = req_sel[4*i +: 4];
        win_op0 = req_op0[32*i +: 32];
        win_op1 = req_op1[32*i +: 32];
      end
    end
  end

  // Next-state and handshake logic.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    sel_d         = sel_q;
    op0_d         = op0_q;
    op1_d         = op1_q;
    id_d          = id_q;
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    resp_err_d    = resp_err_q;
    req_ready     = '0;
    case (state_q)
      IDLE: begin
        if (pick_any && !rst) begin
          req_ready    = pick_grant;
          sel_d        = win_sel;
          op0_d        = win_op0;
          op1_d        = win_op1;
          id_d         = pick_idx;
          last_grant_d = pick_idx;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        resp_err_d    = is_illegal_sel(sel_q);
        resp_result_d = is_illegal_sel(sel_q) ? 32'd0 : alu_result;
        resp_id_d     = id_q;
        resp_valid_d  = 1'b1;
        state_d       = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= ID_W'(NUM_REQ - 1);
      sel_q         <= '0;
      op0_q         <= '0;
      op1_q         <= '0;
      id_q          <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_result_q <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      sel_q         <= sel_d;
      op0_q         <= op0_d;
      op1_q         <= op1_d;
      id_q          <= id_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
      resp_err_q    <= resp_err_d;
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_result = resp_result_q;
  assign resp_err    = resp_err_q;
  assign busy        = (state_q != IDLE);

`ifdef ALU_RR_SCHEDULER_PERF_EN
  logic [31:0] grant_cnt_q [NUM_REQ];
  logic [31:0] grant_cnt_d [NUM_REQ];
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count grants per requester and cycles spent waiting on resp_ready.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_cnt_d[i] = grant_cnt_q[i];
      if (state_q == IDLE && pick_grant[i])
        grant_cnt_d[i] = grant_cnt_q[i] + 32'd1;
    end
    stall_cnt_d = stall_cnt_q;
    if (state_q == RESP && !resp_ready)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= grant_cnt_d[i];
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) grant_cnt[32*i +: 32] = grant_cnt_q[i];
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: directed scenarios with literal expectations,
// then randomized requesters, all tracked by a transaction-level model.
`timescale 1ns/1ps

module tb_alu_rr_scheduler;
  import alu_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [4*NUM_REQ-1:0]  req_sel;
  logic [32*NUM_REQ-1:0] req_op0;
  logic [32*NUM_REQ-1:0] req_op1;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_result;
  logic                  resp_err;
  logic                  busy;
`ifdef ALU_RR_SCHEDULER_PERF_EN
  logic [32*NUM_REQ-1:0] grant_cnt;
  logic [31:0]           stall_cnt;
`endif

  logic [3:0]  r_sel [NUM_REQ];
  logic [31:0] r_op0 [NUM_REQ];
  logic [31:0] r_op1 [NUM_REQ];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_sel[4*i +: 4]   = r_sel[i];
      req_op0[32*i +: 32] = r_op0[i];
      req_op1[32*i +: 32] = r_op1[i];
    end
  end

  alu_rr_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_sel     (req_sel),
    .req_op0     (req_op0),
    .req_op1     (req_op1),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_err    (resp_err),
    .busy        (busy)
`ifdef ALU_RR_SCHEDULER_PERF_EN
    ,
    .grant_cnt   (grant_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model: one operation in flight at most; the response
  // becomes visible one edge after the accepting edge and stays until taken.
  bit          m_busy;
  int          m_age;
  int          m_last;
  int          m_id;
  logic [31:0] m_res;
  logic        m_err;
  int          m_stall;
  logic [31:0] m_gcnt [NUM_REQ];
  int          acc_id;
  bit          resp_hs;
  int          cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  function automatic int rr_winner(input logic [NUM_REQ-1:0] v, input int last);
    int order [$];
    for (int k = 1; k <= NUM_REQ; k++) order.push_back((last + k) % NUM_REQ);
    foreach (order[j]) if (v[order[j]]) return order[j];
    return -1;
  endfunction

  function automatic void ref_alu(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
    int sa, sb;
    sa = a;
    sb = b;
    e  = 1'b0;
    case (s)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd6: r = a << b[4:0];
      4'd7: r = a >> b[4:0];
      4'd8: r = 32'(sa >>> b[4:0]);
      4'd9: r = (sa < sb) ? 32'd1 : 32'd0;
      default: begin r = 32'd0; e = 1'b1; end
    endcase
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_age   = 0;
    m_last  = NUM_REQ - 1;
    m_stall = 0;
    for (int i = 0; i < NUM_REQ; i++) m_gcnt[i] = '0;
  endtask

  // One clock: compare at the falling edge, advance the model, return 1ns
  // after the rising edge so the caller can drive the next inputs.
  task automatic step();
    int w;
    bit exp_valid;
    logic [NUM_REQ-1:0] exp_ready;
    acc_id  = -1;
    resp_hs = 0;
    @(negedge clk);
    if (!rst) begin
      w         = m_busy ? -1 : rr_winner(req_valid, m_last);
      exp_ready = (w >= 0) ? (NUM_REQ'(1) << w) : '0;
      exp_valid = m_busy && (m_age >= 1);
      chk("req_ready", req_ready, exp_ready);
      chk("busy", busy, m_busy);
      chk("resp_valid", resp_valid, exp_valid);
      if (exp_valid) begin
        chk("resp_id", resp_id, m_id);
        chk("resp_result", resp_result, m_res);
        chk("resp_err", resp_err, m_err);
      end
`ifdef ALU_RR_SCHEDULER_PERF_EN
      chk("stall_cnt", stall_cnt, m_stall);
      for (int i = 0; i < NUM_REQ; i++) chk("grant_cnt", grant_cnt[32*i +: 32], m_gcnt[i]);
`endif
      if (w >= 0) begin
        m_busy = 1;
        m_age  = 0;
        m_last = w;
        m_id   = w;
        ref_alu(r_sel[w], r_op0[w], r_op1[w], m_res, m_err);
        m_gcnt[w] = m_gcnt[w] + 32'd1;
        acc_id = w;
      end else if (m_busy) begin
        if (exp_valid && resp_ready) begin
          m_busy  = 0;
          resp_hs = 1;
        end else begin
          if (exp_valid) m_stall++;
          if (m_age < 2) m_age++;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_accept(input string name, input int max_cyc);
    int n = 0;
    do begin
      step();
      n++;
    end while (acc_id < 0 && n < max_cyc);
    if (acc_id < 0) fail_timeout(name);
  endtask

  task automatic wait_resp(input string name, input int max_cyc);
    int n = 0;
    while (resp_valid !== 1'b1 && n < max_cyc) begin
      step();
      n++;
    end
    if (resp_valid !== 1'b1) fail_timeout(name);
  endtask

  task automatic drain();
    int n = 0;
    while (busy !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    if (busy !== 1'b0) fail_timeout("drain");
  endtask

  task automatic single_op(input int id, input logic [3:0] s, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_r, input logic exp_e);
    r_sel[id]  = s;
    r_op0[id]  = a;
    r_op1[id]  = b;
    req_valid  = NUM_REQ'(1) << id;
    resp_ready = 1'b1;
    wait_accept("single_accept", 10);
    chk("single_grant", acc_id, id);
    req_valid = '0;
    wait_resp("single_resp", 5);
    chk("single_result", resp_result, exp_r);
    chk("single_err", resp_err, exp_e);
    chk("single_id", resp_id, id);
    step();
  endtask

  task automatic rand_payload(input int i);
    logic [31:0] pool [5];
    pool[0] = $urandom();
    pool[1] = 32'd0;
    pool[2] = 32'h7FFF_FFFF;
    pool[3] = 32'h8000_0000;
    pool[4] = 32'hFFFF_FFFF;
    r_sel[i] = 4'($urandom_range(0, 15));
    r_op0[i] = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom();
    r_op1[i] = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom();
    if (r_sel[i] inside {SHL_LOGICAL, SHR_LOGICAL, SHR_ARITHMETIC})
      r_op1[i] = 32'($urandom_range(0, 31));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res0;
    logic [31:0] r_chk;
    logic        e_chk;
    int          prev;
`ifdef ALU_RR_SCHEDULER_PERF_EN
    logic [31:0] stall0;
`endif

    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      r_sel[i] = '0;
      r_op0[i] = '0;
      r_op1[i] = '0;
    end
    model_reset();
    #2;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_resp_result", resp_result, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_busy", busy, 0);

    // Pin the reference model against hand-computed values.
    ref_alu(ADD, 32'h7FFF_FFFF, 32'd1, r_chk, e_chk);
    chk("model_add", {r_chk, 31'd0, e_chk}, {32'h8000_0000, 32'd0});
    ref_alu(SHR_ARITHMETIC, 32'hF000_0000, 32'd4, r_chk, e_chk);
    chk("model_sra", r_chk, 32'hFF00_0000);
    ref_alu(LESS_THAN, 32'hFFFF_FFFF, 32'd0, r_chk, e_chk);
    chk("model_slt", r_chk, 32'd1);
    ref_alu(4'b0101, 32'd5, 32'd3, r_chk, e_chk);
    chk("model_illegal", {r_chk, 31'd0, e_chk}, {32'd0, 32'd1});

    step();
    step();
    rst = 1'b0;

    // First operation: requester 0, overflow into the sign bit.
    r_sel[0]   = ADD;
    r_op0[0]   = 32'h7FFF_FFFF;
    r_op1[0]   = 32'd1;
    req_valid  = 4'b0001;
    resp_ready = 1'b1;
    #1;
    chk("t1_req_ready", req_ready, 4'b0001);
    step();
    chk("t1_grant", acc_id, 0);
    req_valid = '0;
    step();
    chk("t1_resp_valid", resp_valid, 1);
    chk("t1_resp_id", resp_id, 0);
    chk("t1_resp_result", resp_result, 32'h8000_0000);
    chk("t1_resp_err", resp_err, 0);
    step();
    chk("t1_idle", busy, 0);

    // All four requesting after reset: 0,1,2,3,0 with 3-cycle spacing.
    rst = 1'b1;
    model_reset();
    step();
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      r_sel[i] = ADD;
      r_op0[i] = 32'(i * 16);
      r_op1[i] = 32'd1;
    end
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_accept("rr_accept", 10);
      chk("rr_order", acc_id, k % NUM_REQ);
      if (k > 0) chk("rr_spacing", cyc - prev, 3);
      prev = cyc;
    end
    req_valid = '0;
    drain();

    single_op(2, SHR_ARITHMETIC, 32'hF000_0000, 32'd4, 32'hFF00_0000, 1'b0);
    single_op(1, LESS_THAN, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0);

    // Illegal opcode still advances the pointer.
    single_op(1, 4'b1011, 32'd5, 32'd3, 32'd0, 1'b1);
    for (int i = 0; i < NUM_REQ; i++) r_sel[i] = ADD;
    req_valid = 4'b1111;
    wait_accept("ptr_accept", 10);
    chk("ptr_after_illegal", acc_id, 2);
    req_valid = '0;
    drain();

    // Back-pressure: response held for five cycles, nobody granted.
    r_sel[0]   = XOR;
    r_op0[0]   = 32'hA5A5_0000;
    r_op1[0]   = 32'h0F0F_FFFF;
    req_valid  = 4'b0001;
    resp_ready = 1'b0;
    wait_accept("stall_accept", 10);
    req_valid = 4'b1111;
    wait_resp("stall_resp", 5);
    res0 = resp_result;
    chk("stall_result", res0, 32'hAAAA_FFFF);
`ifdef ALU_RR_SCHEDULER_PERF_EN
    stall0 = stall_cnt;
`endif
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_hold_valid", resp_valid, 1);
      chk("stall_hold_result", resp_result, 32'hAAAA_FFFF);
      chk("stall_hold_id", resp_id, 0);
      chk("stall_no_grant", req_ready, 0);
    end
`ifdef ALU_RR_SCHEDULER_PERF_EN
    chk("stall_cnt_5", stall_cnt - stall0, 5);
`endif
    req_valid  = '0;
    resp_ready = 1'b1;
    step();
    drain();

    // Reset while an operation is in EXEC.
    r_sel[1]  = ADD;
    r_op0[1]  = 32'd9;
    r_op1[1]  = 32'd9;
    req_valid = 4'b0010;
    wait_accept("rst_exec_accept", 10);
    chk("rst_exec_grant", acc_id, 1);
    req_valid = '0;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_exec_busy", busy, 0);
    chk("rst_exec_resp_valid", resp_valid, 0);
    step();
    rst = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("rst_exec_next_ready", req_ready, 4'b0001);
    wait_accept("rst_exec_next", 10);
    chk("rst_exec_next_grant", acc_id, 0);
    req_valid = '0;
    drain();

    // Randomized requesters, withdrawals, back-pressure and rare resets.
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc_id == i) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          if (req_valid[i]) rand_payload(i);
        end else if (!req_valid[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            rand_payload(i);
            req_valid[i] = 1'b1;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        model_reset();
        step();
        rst = 1'b0;
      end
      step();
    end
    req_valid  = '0;
    resp_ready = 1'b1;
    step();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
